alu_result_skid_stage: RTL and testbench

//  Registered output stage directly downstream of the ALU32 result mux (mux4x1module bit-slices).

---
 rtl/alu_result_skid_stage_if.sv | 41 ++++
 rtl/alu_result_skid_stage.sv | 121 ++++++++++++
 tb/tb_alu_result_skid_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_result_skid_stage_if.sv
// rtl/alu_result_skid_stage_if.sv - handshake and result bundle between the ALU and its output skid stage
// ALU_RESULT_PARITY_EN adds the out_parity member.
interface alu_result_skid_stage_if #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic             in_carry;
   logic             in_overflow;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_neg;
   logic             out_carry;
   logic             out_overflow;
   logic [CNTW-1:0]  out_count;
`ifdef ALU_RESULT_PARITY_EN
   logic             out_parity;
`endif

   modport slave (
      input  in_valid, in_result, in_carry, in_overflow, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_neg,
      output out_carry, out_overflow, out_count
`ifdef ALU_RESULT_PARITY_EN
      , output out_parity
`endif
   );

   modport master (
      output in_valid, in_result, in_carry, in_overflow, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_neg,
      input  out_carry, out_overflow, out_count
`ifdef ALU_RESULT_PARITY_EN
      , input out_parity
`endif
   );
endinterface

// File: rtl/alu_result_skid_stage.sv
// rtl/alu_result_skid_stage.sv - 2-entry skid buffer for ALU result and flags, registered in_ready
// Optional per-entry even parity under ALU_RESULT_PARITY_EN.
module alu_result_skid_stage #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_result_skid_stage_if.slave bus
);
`ifdef ALU_RESULT_PARITY_EN
   localparam int EW = WIDTH + 5;
`else
   localparam int EW = WIDTH + 4;
`endif
   localparam int B_ZERO = WIDTH;
   localparam int B_NEG  = WIDTH + 1;
   localparam int B_CY   = WIDTH + 2;
   localparam int B_OV   = WIDTH + 3;
   // Reset image: result 0 with the zero flag set, everything else clear.
   localparam logic [EW-1:0] RST_ENTRY = {{(EW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [EW-1:0]   r_main;
   logic [EW-1:0]   r_skid;
   logic [CNTW-1:0] r_count;
   logic [EW-1:0]   w_in_entry;
   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_in_xfer;
   logic            w_out_xfer;
   logic            w_load_main;
   logic            w_load_skid;
   logic            w_skid_to_main;

   assign w_in_ready  = (r_state != S_FULL);
   assign w_out_valid = (r_state != S_EMPTY);
   assign w_in_xfer   = bus.in_valid & w_in_ready;
   assign w_out_xfer  = w_out_valid & bus.out_ready;

   always_comb begin
      w_in_entry               = '0;
      w_in_entry[WIDTH-1:0]    = bus.in_result;
      w_in_entry[B_ZERO]       = (bus.in_result == '0);
      w_in_entry[B_NEG]        = bus.in_result[WIDTH-1];
      w_in_entry[B_CY]         = bus.in_carry;
      w_in_entry[B_OV]         = bus.in_overflow;
`ifdef ALU_RESULT_PARITY_EN
      w_in_entry[WIDTH+4]      = ^bus.in_result;
`endif
   end

   always_comb begin
      w_next_state   = r_state;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_in_xfer) begin
               w_load_main  = 1'b1;
               w_next_state = S_ONE;
            end
         end
         S_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_load_main = 1'b1;
            end else if (w_in_xfer) begin
               w_load_skid  = 1'b1;
               w_next_state = S_FULL;
            end else if (w_out_xfer) begin
               w_next_state = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_out_xfer) begin
               w_skid_to_main = 1'b1;
               w_next_state   = S_ONE;
            end
         end
         default: w_next_state = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_main  <= RST_ENTRY;
         r_skid  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_load_main) begin
            r_main <= w_in_entry;
         end else if (w_skid_to_main) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in_entry;
         end
         if (w_in_xfer) begin
            r_count <= r_count + CNTW'(1);
         end
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = w_out_valid;
   assign bus.out_result   = r_main[WIDTH-1:0];
   assign bus.out_zero     = r_main[B_ZERO];
   assign bus.out_neg      = r_main[B_NEG];
   assign bus.out_carry    = r_main[B_CY];
   assign bus.out_overflow = r_main[B_OV];
   assign bus.out_count    = r_count;
`ifdef ALU_RESULT_PARITY_EN
   assign bus.out_parity   = r_main[WIDTH+4];
`endif
endmodule

// File: tb/tb_alu_result_skid_stage.sv
// tb/tb_alu_result_skid_stage.sv - directed self-checking bench for alu_result_skid_stage (CNTW=4 build)
module tb_alu_result_skid_stage;
   localparam int WIDTH = 32;
   localparam int CNTW  = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   alu_result_skid_stage_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus_if ();

   alu_result_skid_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic cy, input logic ov);
      bus_if.in_valid    = v;
      bus_if.in_result   = d;
      bus_if.in_carry    = cy;
      bus_if.in_overflow = ov;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      bus_if.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_out_valid", bus_if.out_valid, 0);
      check("rst_in_ready", bus_if.in_ready, 1);
      check("rst_count", bus_if.out_count, 0);
      check("rst_zero", bus_if.out_zero, 1);
      check("rst_result", bus_if.out_result, 0);

      // single pass
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b0);
      bus_if.out_ready = 1'b1;
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("single_flags", {bus_if.out_valid, bus_if.out_neg, bus_if.out_zero, bus_if.out_carry, bus_if.out_overflow}, 5'b11010);
      check("single_result", bus_if.out_result, 32'h8000_0000);
      check("single_count", bus_if.out_count, 1);
      step();
      check("single_drained", bus_if.out_valid, 0);

      // back-pressure
      bus_if.out_ready = 1'b0;
      drive(1'b1, 32'h1, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'h0, 1'b1, 1'b0);
      step();
      check("bp_full_in_ready", bus_if.in_ready, 0);
      check("bp_head", {bus_if.out_valid, bus_if.out_overflow, bus_if.out_result}, {1'b1, 1'b1, 32'h1});
      drive(1'b1, 32'h5, 1'b0, 1'b0);
      step();
      step();
      check("bp_hold_in_ready", bus_if.in_ready, 0);
      check("bp_hold_stable", {bus_if.out_zero, bus_if.out_overflow, bus_if.out_result}, {1'b0, 1'b1, 32'h1});
      check("bp_hold_count", bus_if.out_count, 3);
      bus_if.out_ready = 1'b1;
      step();
      check("bp_second", {bus_if.out_valid, bus_if.out_zero, bus_if.out_carry, bus_if.out_result}, {1'b1, 1'b1, 1'b1, 32'h0});
      check("bp_reopen", bus_if.in_ready, 1);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("bp_third", {bus_if.out_valid, bus_if.out_zero, bus_if.out_result}, {1'b1, 1'b0, 32'h5});
      check("bp_count", bus_if.out_count, 4);
      step();
      check("bp_empty", bus_if.out_valid, 0);

      // streaming: 100 words, one per cycle
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 32'(100 + i), 1'b0, 1'b0);
         step();
         check("stream", {bus_if.out_valid, bus_if.in_ready, bus_if.out_result}, {1'b1, 1'b1, 32'(100 + i)});
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("stream_count", bus_if.out_count, (4 + 100) % 16);
      step();
      check("stream_empty", bus_if.out_valid, 0);

      // reset while full, with a transfer offered in the reset cycle
      bus_if.out_ready = 1'b0;
      drive(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h5555_5555, 1'b0, 1'b0);
      step();
      check("mid_full", {bus_if.in_ready, bus_if.out_result}, {1'b0, 32'hAAAA_AAAA});
      rst = 1'b1;
      drive(1'b1, 32'h1234, 1'b0, 1'b0);
      bus_if.out_ready = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("mid_rst_state", {bus_if.out_valid, bus_if.in_ready, bus_if.out_zero}, 3'b011);
      check("mid_rst_count", bus_if.out_count, 0);
      check("mid_rst_result", bus_if.out_result, 0);
      step();
      check("mid_rst_discard", {bus_if.out_valid, bus_if.out_count}, 0);

`ifdef ALU_RESULT_PARITY_EN
      drive(1'b1, 32'h7, 1'b0, 1'b0);
      step();
      check("parity_odd", bus_if.out_parity, 1);
      drive(1'b1, 32'h3, 1'b0, 1'b0);
      step();
      check("parity_even", bus_if.out_parity, 0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      step();
`endif

      // counter wrap: 17 transfers from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 32'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("wrap_count", bus_if.out_count, 1);
      check("wrap_last", bus_if.out_result, 16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
